// File: rtl/pipemem_pkg.sv
// Shared encodings, load-control struct and helpers for the pipeline memory / I-O stage.
package pipemem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Everything needed one cycle later to format the load result.
  typedef struct packed {
    logic       io;
    logic       uns;
    logic [1:0] size;
    logic [1:0] lane;
  } ld_ctl_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return a[0];
      SZ_WORD: return |a;
      default: return 1'b1;
    endcase
  endfunction

  // Bit replicated above the loaded lane(s).
  function automatic logic ext_fill(input logic [1:0] size, input logic uns,
                                    input logic byte_msb, input logic half_msb);
    if (uns) return 1'b0;
    case (size)
      SZ_BYTE: return byte_msb;
      SZ_HALF: return half_msb;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipemem_bram.sv
// Single-port data RAM: byte-enable write, synchronous write-first read.
module pipemem_bram #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);
  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  logic [DATA_W-1:0] fwd;

  always_comb begin
    fwd = mem[addr];
    for (int i = 0; i < LANES; i++)
      if (we && be[i]) fwd[8*i +: 8] = wdata[8*i +: 8];
  end

  // Array itself is never reset; only the read register is.
  always_ff @(posedge clock) begin
    if (we)
      for (int i = 0; i < LANES; i++)
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= fwd;
  end

endmodule

// File: rtl/pipemem_io.sv
// Pipeline memory stage: byte-addressed data RAM plus memory-mapped input/output ports.
module pipemem_io
  import pipemem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 5,
  parameter int N_IN       = 2,
  parameter int N_OUT      = 4,
  parameter int IO_SEL_BIT = 7
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mwmem,
  input  logic                    mrmem,
  input  logic [1:0]              msize,
  input  logic                    munsigned,
  input  logic [DATA_W-1:0]       malu,
  input  logic [DATA_W-1:0]       mb,
  input  logic [N_IN*DATA_W-1:0]  in_port,
  output logic [N_OUT*DATA_W-1:0] out_port,
  output logic [N_OUT-1:0]        out_strobe,
  output logic [DATA_W-1:0]       mmo,
  output logic                    write_datamem_enable,
  output logic                    misalign
);
  localparam int LANES = DATA_W / 8;
  localparam int IO_W  = IO_SEL_BIT - 2;

  logic                             is_io, mis, ld_en, io_wr;
  logic [DEPTH_LOG2-1:0]            ram_idx;
  logic [IO_W-1:0]                  io_idx;
  logic [LANES-1:0]                 be;
  logic [DATA_W-1:0]                wdata, io_rd, io_q, ram_q, raw;
  logic [N_IN-1:0][DATA_W-1:0]      in_a, sync1, sync2;
  logic [N_OUT-1:0][DATA_W-1:0]     out_r;
  ld_ctl_t                          ld_q;
  logic [7:0]                       byte_v;
  logic [15:0]                      half_v;
  logic                             fill;

  wire unused_hi = &{1'b0, malu[DATA_W-1:IO_SEL_BIT+1]};

  assign is_io    = malu[IO_SEL_BIT];
  assign ram_idx  = malu[2 +: DEPTH_LOG2];
  assign io_idx   = malu[2 +: IO_W];
  assign mis      = is_misaligned(msize, malu[1:0]);
  assign ld_en    = mrmem & ~mwmem & ~mis;
  assign io_wr    = mwmem & is_io & ~mis & (msize == SZ_WORD);
  assign in_a     = in_port;
  assign out_port = out_r;

  assign write_datamem_enable = mwmem & ~is_io & ~mis;

  always_comb begin
    be    = '0;
    wdata = mb;
    case (msize)
      SZ_BYTE: begin
        be    = LANES'(1) << malu[1:0];
        wdata = {LANES{mb[7:0]}};
      end
      SZ_HALF: begin
        be    = LANES'(3) << {malu[1], 1'b0};
        wdata = {(LANES/2){mb[15:0]}};
      end
      SZ_WORD: be = '1;
      default: be = '0;
    endcase
  end

  pipemem_bram #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_bram (
    .clock (clock),
    .reset (reset),
    .we    (write_datamem_enable),
    .be    (be),
    .re    (ld_en & ~is_io),
    .addr  (ram_idx),
    .wdata (wdata),
    .rdata (ram_q)
  );

  // I/O read map: synchronised inputs first, then read-back of the output registers.
  always_comb begin
    io_rd = '0;
    for (int k = 0; k < N_IN; k++)
      if (int'(io_idx) == k) io_rd = sync2[k];
    for (int k = 0; k < N_OUT; k++)
      if (int'(io_idx) == N_IN + k) io_rd = out_r[k];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_a;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_r      <= '0;
      out_strobe <= '0;
      misalign   <= 1'b0;
      ld_q       <= '0;
      io_q       <= '0;
    end else begin
      out_strobe <= '0;
      misalign   <= (mwmem | mrmem) & mis;
      for (int k = 0; k < N_OUT; k++)
        if (io_wr && int'(io_idx) == k) begin
          out_r[k]      <= mb;
          out_strobe[k] <= 1'b1;
        end
      if (ld_en) begin
        ld_q <= '{io: is_io, uns: munsigned, size: msize, lane: malu[1:0]};
        if (is_io) io_q <= io_rd;
      end
    end
  end

  // Result is formatted from registered state only, so it holds until the next load.
  always_comb begin
    raw    = ld_q.io ? io_q : ram_q;
    byte_v = raw[8*ld_q.lane +: 8];
    half_v = raw[16*ld_q.lane[1] +: 16];
    fill   = ext_fill(ld_q.size, ld_q.uns, byte_v[7], half_v[15]);
    case (ld_q.size)
      SZ_BYTE: mmo = {{(DATA_W-8){fill}}, byte_v};
      SZ_HALF: mmo = {{(DATA_W-16){fill}}, half_v};
      default: mmo = raw;
    endcase
  end

endmodule

// File: tb/tb_pipemem_io.sv
// Directed self-checking bench for pipemem_io with hand-computed expectations.
module tb_pipemem_io;
  localparam int DATA_W = 32, DEPTH_LOG2 = 5, N_IN = 2, N_OUT = 4, IO_SEL_BIT = 7;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

  logic clock = 1'b0, reset = 1'b0;
  logic mwmem = 1'b0, mrmem = 1'b0, munsigned = 1'b0;
  logic [1:0] msize = 2'b00;
  logic [DATA_W-1:0] malu = '0, mb = '0;
  logic [N_IN*DATA_W-1:0] in_port = '0;
  logic [N_OUT*DATA_W-1:0] out_port;
  logic [N_OUT-1:0] out_strobe;
  logic [DATA_W-1:0] mmo;
  logic write_datamem_enable, misalign;
  int checks = 0, errors = 0;

  pipemem_io #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .N_IN(N_IN), .N_OUT(N_OUT),
               .IO_SEL_BIT(IO_SEL_BIT)) dut (
    .clock(clock), .reset(reset), .mwmem(mwmem), .mrmem(mrmem), .msize(msize),
    .munsigned(munsigned), .malu(malu), .mb(mb), .in_port(in_port), .out_port(out_port),
    .out_strobe(out_strobe), .mmo(mmo), .write_datamem_enable(write_datamem_enable),
    .misalign(misalign));

  always #5 clock = ~clock;

  task automatic step(); @(posedge clock); #1; endtask
  task automatic idle(); mwmem = 1'b0; mrmem = 1'b0; endtask
  task automatic req(input logic wr, input logic rd, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] d);
    mwmem = wr; mrmem = rd; msize = sz; munsigned = uns; malu = a; mb = d;
  endtask
  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    req(1'b1, 1'b0, sz, 1'b0, a, d); step(); idle();
  endtask
  task automatic load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    req(1'b0, 1'b1, sz, uns, a, 32'h0); step(); idle();
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++; if (out_port !== '0) begin errors++; $display("FAIL reset_out_port got %h exp 0", out_port); end
    checks++; if (out_strobe !== 4'b0) begin errors++; $display("FAIL reset_strobe got %b exp 0000", out_strobe); end
    checks++; if (mmo !== 32'h0) begin errors++; $display("FAIL reset_mmo got %h exp 0", mmo); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", misalign); end
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_word_byte();
    req(1'b1, 1'b0, W, 1'b0, 32'h08, 32'h12345678); #1;
    checks++; if (write_datamem_enable !== 1'b1) begin errors++; $display("FAIL wde_ram_store got %b exp 1", write_datamem_enable); end
    step(); idle();
    load(B, 1'b1, 32'h0B);
    checks++; if (mmo !== 32'h00000012) begin errors++; $display("FAIL ld_byte_u_0B got %h exp 00000012", mmo); end
    step();
    checks++; if (mmo !== 32'h00000012) begin errors++; $display("FAIL mmo_hold got %h exp 00000012", mmo); end
    load(H, 1'b1, 32'h0A);
    checks++; if (mmo !== 32'h00001234) begin errors++; $display("FAIL ld_half_u_0A got %h exp 00001234", mmo); end
    load(W, 1'b0, 32'h108);
    checks++; if (mmo !== 32'h12345678) begin errors++; $display("FAIL ld_word_hi_ignored got %h exp 12345678", mmo); end
  endtask

  task automatic test_byte_ext();
    store(W, 32'h04, 32'h0);
    store(B, 32'h04, 32'h123456FF);
    load(H, 1'b0, 32'h04);
    checks++; if (mmo !== 32'h000000FF) begin errors++; $display("FAIL ld_half_s_04 got %h exp 000000FF", mmo); end
    load(B, 1'b0, 32'h04);
    checks++; if (mmo !== 32'hFFFFFFFF) begin errors++; $display("FAIL ld_byte_s_04 got %h exp FFFFFFFF", mmo); end
    store(B, 32'h06, 32'h00000080);
    load(B, 1'b0, 32'h06);
    checks++; if (mmo !== 32'hFFFFFF80) begin errors++; $display("FAIL ld_byte_s_06 got %h exp FFFFFF80", mmo); end
    load(B, 1'b1, 32'h06);
    checks++; if (mmo !== 32'h00000080) begin errors++; $display("FAIL ld_byte_u_06 got %h exp 00000080", mmo); end
    load(W, 1'b0, 32'h04);
    checks++; if (mmo !== 32'h008000FF) begin errors++; $display("FAIL ld_word_04 got %h exp 008000FF", mmo); end
    store(W, 32'h0C, 32'h0);
    store(H, 32'h0E, 32'h1234BEEF);
    load(H, 1'b0, 32'h0E);
    checks++; if (mmo !== 32'hFFFFBEEF) begin errors++; $display("FAIL ld_half_s_0E got %h exp FFFFBEEF", mmo); end
    load(W, 1'b0, 32'h0C);
    checks++; if (mmo !== 32'hBEEF0000) begin errors++; $display("FAIL ld_word_0C got %h exp BEEF0000", mmo); end
  endtask

  task automatic test_conflict();
    req(1'b1, 1'b1, W, 1'b0, 32'h10, 32'hCAFEF00D); step(); idle();
    checks++; if (mmo !== 32'hBEEF0000) begin errors++; $display("FAIL st_ld_mmo_held got %h exp BEEF0000", mmo); end
    load(W, 1'b0, 32'h10);
    checks++; if (mmo !== 32'hCAFEF00D) begin errors++; $display("FAIL st_ld_stored got %h exp CAFEF00D", mmo); end
  endtask

  task automatic test_io_write();
    req(1'b1, 1'b0, W, 1'b0, 32'h84, 32'hA5); #1;
    checks++; if (write_datamem_enable !== 1'b0) begin errors++; $display("FAIL wde_io_store got %b exp 0", write_datamem_enable); end
    step(); idle();
    checks++; if (out_port[63:32] !== 32'hA5) begin errors++; $display("FAIL io_out1 got %h exp 000000A5", out_port[63:32]); end
    checks++; if (out_strobe !== 4'b0010) begin errors++; $display("FAIL io_strobe got %b exp 0010", out_strobe); end
    step();
    checks++; if (out_strobe !== 4'b0000) begin errors++; $display("FAIL io_strobe_pulse got %b exp 0000", out_strobe); end
    load(W, 1'b0, 32'h8C);
    checks++; if (mmo !== 32'hA5) begin errors++; $display("FAIL io_readback got %h exp 000000A5", mmo); end
    store(B, 32'h80, 32'h77);
    checks++; if (out_strobe !== 4'b0 || out_port[31:0] !== 32'h0) begin errors++; $display("FAIL io_byte_ignored got %b/%h exp 0000/0", out_strobe, out_port[31:0]); end
    store(W, 32'h98, 32'h99);
    checks++; if (out_strobe !== 4'b0 || misalign !== 1'b0) begin errors++; $display("FAIL io_idx_oob got %b/%b exp 0000/0", out_strobe, misalign); end
    load(W, 1'b0, 32'hA8);
    checks++; if (mmo !== 32'h0) begin errors++; $display("FAIL io_read_oob got %h exp 0", mmo); end
  endtask

  task automatic test_in_sync();
    in_port[31:0] = 32'h55;
    step();
    load(W, 1'b0, 32'h80);
    checks++; if (mmo !== 32'h0) begin errors++; $display("FAIL sync_early got %h exp 0", mmo); end
    load(W, 1'b0, 32'h80);
    checks++; if (mmo !== 32'h55) begin errors++; $display("FAIL sync_late got %h exp 00000055", mmo); end
    in_port[63:32] = 32'h66;
    step(); step();
    load(W, 1'b0, 32'h84);
    checks++; if (mmo !== 32'h66) begin errors++; $display("FAIL sync_port1 got %h exp 00000066", mmo); end
  endtask

  task automatic test_misalign();
    req(1'b1, 1'b0, W, 1'b0, 32'h06, 32'hDEADBEEF); #1;
    checks++; if (write_datamem_enable !== 1'b0) begin errors++; $display("FAIL mis_wde got %b exp 0", write_datamem_enable); end
    step(); idle();
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_pulse got %b exp 1", misalign); end
    step();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_one_cycle got %b exp 0", misalign); end
    load(W, 1'b0, 32'h04);
    checks++; if (mmo !== 32'h008000FF) begin errors++; $display("FAIL mis_ram_kept got %h exp 008000FF", mmo); end
    load(H, 1'b0, 32'h05);
    checks++; if (mmo !== 32'h008000FF || misalign !== 1'b1) begin errors++; $display("FAIL mis_load got %h/%b exp 008000FF/1", mmo, misalign); end
    load(R, 1'b0, 32'h08);
    checks++; if (mmo !== 32'h008000FF || misalign !== 1'b1) begin errors++; $display("FAIL mis_rsvd got %h/%b exp 008000FF/1", mmo, misalign); end
  endtask

  task automatic test_async_reset();
    store(W, 32'h80, 32'hFFFF);
    checks++; if (out_port[31:0] !== 32'hFFFF) begin errors++; $display("FAIL pre_rst_out0 got %h exp 0000FFFF", out_port[31:0]); end
    load(W, 1'b0, 32'h08);
    #2 reset = 1'b1;
    #1;
    checks++; if (out_port !== '0) begin errors++; $display("FAIL async_rst_out got %h exp 0", out_port); end
    checks++; if (mmo !== 32'h0) begin errors++; $display("FAIL async_rst_mmo got %h exp 0", mmo); end
    req(1'b1, 1'b0, W, 1'b0, 32'h84, 32'h1234); step(); idle();
    checks++; if (out_port !== '0 || out_strobe !== 4'b0) begin errors++; $display("FAIL rst_store_blocked got %h/%b exp 0/0000", out_port, out_strobe); end
    reset = 1'b0;
    load(W, 1'b0, 32'h08);
    checks++; if (mmo !== 32'h12345678) begin errors++; $display("FAIL ram_after_rst got %h exp 12345678", mmo); end
  endtask

  initial begin
    test_reset();
    test_word_byte();
    test_byte_ext();
    test_conflict();
    test_io_write();
    test_in_sync();
    test_misalign();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
